// File: rtl/line_burst_adapter_pkg.sv
// ============================================================================
// Module   : line_burst_pkg
// Purpose  : Shared types and default geometry for the line/burst adapter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package line_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } lb_state_e;

    localparam int LB_LINE_W      = 256;
    localparam int LB_BURST_W     = 64;
    localparam int LB_BEATS       = LB_LINE_W / LB_BURST_W;
    localparam int LB_OFFSET_BITS = 5;

    // Clears the byte offset within a 32-byte line.
    function automatic logic [31:0] lb_align(input logic [31:0] addr);
        return {addr[31:LB_OFFSET_BITS], {LB_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_burst_adapter_if.sv
// ============================================================================
// Module   : line_burst_adapter_if
// Purpose  : Cache-side line bus and memory-side burst bus of the adapter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface line_burst_adapter_if #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
);
    // Cache side
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic [31:0]        address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    // Memory side
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic [31:0]        address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );

endinterface

`default_nettype wire

// File: rtl/line_burst_adapter.sv
// ============================================================================
// Module   : line_burst_adapter
// Purpose  : Assembles BURST_W beats into a cache line on fills and splits a
//            line into beats on writebacks. Define LINE_BURST_FWD_EN to drop
//            the DONE state and complete reads/writes on the last beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_burst_adapter
    import line_burst_pkg::*;
#(
    parameter int LINE_W  = LB_LINE_W,
    parameter int BURST_W = LB_BURST_W
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    line_burst_adapter_if.slave   bus
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

`ifdef LINE_BURST_FWD_EN
    localparam lb_state_e FINAL_STATE = IDLE;
`else
    localparam lb_state_e FINAL_STATE = DONE;
`endif

    lb_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [LINE_W-1:0] line_q,  line_d;
    logic [31:0]       addr_q,  addr_d;

    logic              last_beat;
    logic [LINE_W-1:0] line_out;

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                // Writeback wins so a dirty victim is never lost behind a fill.
                if (bus.write_i) begin
                    line_d  = bus.line_i;
                    addr_d  = lb_align(bus.address_i);
                    cnt_d   = '0;
                    state_d = WRITE;
                end else if (bus.read_i) begin
                    addr_d  = lb_align(bus.address_i);
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (bus.resp_i) begin
                    line_d[BURST_W*cnt_q +: BURST_W] = bus.burst_i;
                    if (last_beat) begin
                        state_d = FINAL_STATE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (bus.resp_i) begin
                    if (last_beat) begin
                        state_d = FINAL_STATE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.read_o    = (state_q == READ);
    assign bus.write_o   = (state_q == WRITE);
    assign bus.address_o = addr_q;
    assign bus.burst_o   = (state_q == WRITE) ? line_q[BURST_W*cnt_q +: BURST_W]
                                              : '0;

`ifdef LINE_BURST_FWD_EN
    assign bus.resp_o = ((state_q == READ) || (state_q == WRITE)) &&
                        bus.resp_i && last_beat;

    // The final beat has not reached line_q yet, so splice it into the top slot.
    always_comb begin
        line_out = line_q;
        if ((state_q == READ) && bus.resp_i && last_beat) begin
            line_out[LINE_W-1 -: BURST_W] = bus.burst_i;
        end
    end
`else
    assign bus.resp_o = (state_q == DONE);
    assign line_out   = line_q;
`endif

    assign bus.line_o = line_out;

endmodule

`default_nettype wire
